// File: rtl/bti_sensor_scan_ctrl.sv
// bti_sensor_scan_ctrl: AXI4-Lite master that periodically starts, polls and reads a BTI sensor.
// Define BTI_SCAN_TIMESTAMP_EN to add result_ts, sampled from a free-running cycle counter.
module bti_sensor_scan_ctrl #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
    parameter int                            PERIOD_W           = 24,
    parameter int                            POLL_MAX           = 1023
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          cfg_enable,
    input  logic [PERIOD_W-1:0]           cfg_period,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] result_data,
    output logic                          result_valid,
    output logic                          busy,
    output logic                          err_resp,
`ifdef BTI_SCAN_TIMESTAMP_EN
    output logic [31:0]                   result_ts,
`endif
    output logic                          err_timeout
);

    localparam int A  = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int PW = $clog2(POLL_MAX + 1);
    localparam logic [A-1:0] ST_ADDR  = BASE_ADDR + A'(4);
    localparam logic [A-1:0] CNT_ADDR = BASE_ADDR + A'(8);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT, S_WR, S_WRESP, S_AR_ST, S_R_ST, S_AR_CNT, S_R_CNT, S_PUB
    } state_t;

    state_t                state_q, state_d;
    logic [PERIOD_W-1:0]   wait_cnt;
    logic                  wait_run, wait_zero;
    logic                  aw_done, w_done, aw_ok, w_ok;
    logic [PW-1:0]         poll_cnt;
    logic                  poll_inc, set_err_resp, set_err_to, pub_load;
    logic                  en_q;
    logic                  r_hs;

    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_AWVALID = (state_q == S_WR) && !aw_done;
    assign M_AXI_WVALID  = (state_q == S_WR) && !w_done;
    assign M_AXI_AWADDR  = (state_q == S_WR) ? BASE_ADDR : '0;
    assign M_AXI_WDATA   = (state_q == S_WR) ? DW'(1) : '0;
    assign M_AXI_BREADY  = (state_q == S_WRESP);
    assign M_AXI_ARVALID = (state_q == S_AR_ST) || (state_q == S_AR_CNT);
    assign M_AXI_ARADDR  = (state_q == S_AR_ST)  ? ST_ADDR :
                           (state_q == S_AR_CNT) ? CNT_ADDR : '0;
    assign M_AXI_RREADY  = (state_q == S_R_ST) || (state_q == S_R_CNT);
    assign result_valid  = (state_q == S_PUB);
    assign busy          = (state_q != S_IDLE);

    assign aw_ok     = aw_done || (M_AXI_AWVALID && M_AXI_AWREADY);
    assign w_ok      = w_done || (M_AXI_WVALID && M_AXI_WREADY);
    assign wait_zero = wait_run ? (wait_cnt == '0) : (cfg_period == '0);
    assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state; a dropped enable only takes effect once the open transaction finishes
    always_comb begin
        state_d      = state_q;
        set_err_resp = 1'b0;
        set_err_to   = 1'b0;
        pub_load     = 1'b0;
        poll_inc     = 1'b0;
        unique case (state_q)
            S_IDLE: if (cfg_enable) state_d = S_WAIT;
            S_WAIT: begin
                if (!cfg_enable)    state_d = S_IDLE;
                else if (wait_zero) state_d = S_WR;
            end
            S_WR: if (aw_ok && w_ok) state_d = S_WRESP;
            S_WRESP: if (M_AXI_BVALID) begin
                if (M_AXI_BRESP != 2'b00) begin
                    set_err_resp = 1'b1;
                    state_d      = cfg_enable ? S_WAIT : S_IDLE;
                end else begin
                    state_d = cfg_enable ? S_AR_ST : S_IDLE;
                end
            end
            S_AR_ST: if (M_AXI_ARREADY) state_d = S_R_ST;
            S_R_ST: if (r_hs) begin
                if (M_AXI_RRESP != 2'b00) begin
                    set_err_resp = 1'b1;
                    state_d      = cfg_enable ? S_WAIT : S_IDLE;
                end else if (M_AXI_RDATA[0]) begin
                    state_d = cfg_enable ? S_AR_CNT : S_IDLE;
                end else if (poll_cnt == PW'(POLL_MAX - 1)) begin
                    set_err_to = 1'b1;
                    state_d    = cfg_enable ? S_WAIT : S_IDLE;
                end else begin
                    poll_inc = 1'b1;
                    state_d  = cfg_enable ? S_AR_ST : S_IDLE;
                end
            end
            S_AR_CNT: if (M_AXI_ARREADY) state_d = S_R_CNT;
            S_R_CNT: if (r_hs) begin
                if (M_AXI_RRESP != 2'b00) begin
                    set_err_resp = 1'b1;
                    state_d      = cfg_enable ? S_WAIT : S_IDLE;
                end else if (cfg_enable) begin
                    pub_load = 1'b1;
                    state_d  = S_PUB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PUB:   state_d = cfg_enable ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Period countdown: first WAIT cycle samples cfg_period, later cycles count to zero
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wait_run <= 1'b0;
            wait_cnt <= '0;
        end else begin
            wait_run <= (state_q == S_WAIT) && (state_d == S_WAIT);
            if (state_q == S_WAIT)
                wait_cnt <= wait_run ? wait_cnt - PERIOD_W'(1)
                                     : cfg_period - PERIOD_W'(1);
        end
    end

    // Per-channel handshake tracking for the CTRL write and the STATUS poll count
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            poll_cnt <= '0;
        end else begin
            aw_done <= (state_q == S_WR) && (state_d == S_WR) && aw_ok;
            w_done  <= (state_q == S_WR) && (state_d == S_WR) && w_ok;
            if (state_q == S_WR) poll_cnt <= '0;
            else if (poll_inc)   poll_cnt <= poll_cnt + PW'(1);
        end
    end

    // Sticky error flags cleared on enable rising edge; result capture
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            en_q        <= 1'b0;
            err_resp    <= 1'b0;
            err_timeout <= 1'b0;
            result_data <= '0;
        end else begin
            en_q <= cfg_enable;
            if (cfg_enable && !en_q) begin
                err_resp    <= 1'b0;
                err_timeout <= 1'b0;
            end else begin
                if (set_err_resp) err_resp    <= 1'b1;
                if (set_err_to)   err_timeout <= 1'b1;
            end
            if (pub_load) result_data <= M_AXI_RDATA;
        end
    end

`ifdef BTI_SCAN_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running timestamp, latched alongside the published result
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ts_cnt    <= '0;
            result_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (pub_load) result_ts <= ts_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bti_sensor_scan_ctrl.sv
// tb_bti_sensor_scan_ctrl: AXI-Lite sensor slave model plus queue scoreboard.
// Expected AW/W/AR/result events are queued up front and popped by a negedge monitor.
module tb_bti_sensor_scan_ctrl;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic        cfg_enable;
    logic [23:0] cfg_period;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [31:0] result_data;
    logic        result_valid, busy, err_resp, err_timeout;
`ifdef BTI_SCAN_TIMESTAMP_EN
    logic [31:0] result_ts;
`endif

    bti_sensor_scan_ctrl #(
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32),
        .BASE_ADDR(BASE), .PERIOD_W(24), .POLL_MAX(4)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cfg_enable(cfg_enable), .cfg_period(cfg_period),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
        .result_data(result_data), .result_valid(result_valid),
        .busy(busy), .err_resp(err_resp),
`ifdef BTI_SCAN_TIMESTAMP_EN
        .result_ts(result_ts),
`endif
        .err_timeout(err_timeout)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Slave configuration
    int aw_dly = 0, w_dly = 0, ar_fix = 0, ar_max = 0, r_max = 0, done_on = 2;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] count_val = 32'h1234;
    int scan_no = 0;

    // Expected event queues
    logic [31:0] aw_q[$], w_q[$], ar_q[$], res_q[$];

`ifdef BTI_SCAN_TIMESTAMP_EN
    logic [31:0] ts_v[4];
    int          cyc_v[4];
    int          ts_n = 0;
`endif

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop(input int ch, input string nm, input logic [31:0] act);
        logic [31:0] e;
        bit ok;
        ok = 1'b1;
        e  = '0;
        case (ch)
            0: if (aw_q.size() > 0) e = aw_q.pop_front(); else ok = 1'b0;
            1: if (w_q.size() > 0)  e = w_q.pop_front();  else ok = 1'b0;
            2: if (ar_q.size() > 0) e = ar_q.pop_front(); else ok = 1'b0;
            default: if (res_q.size() > 0) e = res_q.pop_front(); else ok = 1'b0;
        endcase
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s unexpected: got %h expected none", nm, act);
        end else if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
        end
    endtask

    task automatic push_scan(input int polls, input bit res, input logic [31:0] cnt);
        aw_q.push_back(BASE);
        w_q.push_back(32'h1);
        repeat (polls) ar_q.push_back(BASE + 32'h4);
        if (res) begin
            ar_q.push_back(BASE + 32'h8);
            res_q.push_back(cnt);
        end
    endtask

    function automatic int pending();
        return aw_q.size() + w_q.size() + ar_q.size() + res_q.size();
    endfunction

    task automatic wait_sb(input string nm, input int bound);
        int n;
        n = 0;
        while (pending() != 0 && n < bound) begin
            @(negedge ACLK);
            n++;
        end
        chk(nm, pending(), 0);
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge ACLK);
            n++;
        end
        chk(nm, {31'b0, busy}, 0);
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    // AW channel slave
    initial begin
        M_AXI_AWREADY = 1'b0;
        forever begin
            step();
            if (M_AXI_AWVALID) begin
                repeat (aw_dly) step();
                M_AXI_AWREADY = 1'b1;
                scan_no++;
                step();
                M_AXI_AWREADY = 1'b0;
            end
        end
    end

    // W channel slave
    initial begin
        M_AXI_WREADY = 1'b0;
        forever begin
            step();
            if (M_AXI_WVALID) begin
                repeat (w_dly) step();
                M_AXI_WREADY = 1'b1;
                step();
                M_AXI_WREADY = 1'b0;
            end
        end
    end

    // B channel slave
    initial begin
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
        forever begin
            step();
            if (M_AXI_BREADY) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP  = bresp_cfg;
                step();
                M_AXI_BVALID = 1'b0;
                M_AXI_BRESP  = 2'b00;
            end
        end
    end

    // AR/R channel slave with STATUS done after done_on polls of the current scan
    initial begin
        int polls, seen, d, n;
        logic [31:0] a;
        polls = 0;
        seen  = 0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RDATA   = '0;
        M_AXI_RRESP   = 2'b00;
        forever begin
            step();
            if (M_AXI_ARVALID) begin
                d = (ar_fix >= 0) ? ar_fix : int'($urandom_range(ar_max, 0));
                repeat (d) step();
                M_AXI_ARREADY = 1'b1;
                a = M_AXI_ARADDR;
                step();
                M_AXI_ARREADY = 1'b0;
                d = int'($urandom_range(r_max, 0));
                repeat (d) step();
                if (seen != scan_no) begin
                    seen  = scan_no;
                    polls = 0;
                end
                if (a == BASE + 32'h4) begin
                    polls++;
                    M_AXI_RDATA = {31'b0, (done_on != 0) && (polls >= done_on)};
                end else if (a == BASE + 32'h8) begin
                    M_AXI_RDATA = count_val;
                end else begin
                    M_AXI_RDATA = 32'hDEAD_BEEF;
                end
                M_AXI_RVALID = 1'b1;
                n = 0;
                while (!M_AXI_RREADY && n < 50) begin
                    step();
                    n++;
                end
                step();
                M_AXI_RVALID = 1'b0;
            end
        end
    end

    // Monitor: pop expectations on handshakes, check valid/address hold under stall
    logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
    logic [31:0] aw_pa, ar_pa;
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) pop(0, "aw_addr", M_AXI_AWADDR);
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                pop(1, "w_data", M_AXI_WDATA);
                chk("w_strb", {28'b0, M_AXI_WSTRB}, 32'hF);
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) pop(2, "ar_addr", M_AXI_ARADDR);
            if (result_valid) begin
                pop(3, "result", result_data);
`ifdef BTI_SCAN_TIMESTAMP_EN
                if (ts_n < 4) begin
                    ts_v[ts_n]  = result_ts;
                    cyc_v[ts_n] = cyc;
                    ts_n++;
                end
`endif
            end
            if (aw_pend) chk("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR[30:0]}, {1'b1, aw_pa[30:0]});
            if (w_pend)  chk("w_hold", {31'b0, M_AXI_WVALID}, 32'h1);
            if (ar_pend) chk("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR[30:0]}, {1'b1, ar_pa[30:0]});
            aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
            w_pend  = M_AXI_WVALID && !M_AXI_WREADY;
            ar_pend = M_AXI_ARVALID && !M_AXI_ARREADY;
            aw_pa   = M_AXI_AWADDR;
            ar_pa   = M_AXI_ARADDR;
        end else begin
            aw_pend = 1'b0;
            w_pend  = 1'b0;
            ar_pend = 1'b0;
        end
    end

    initial begin
        int n;
        ARESETN    = 1'b0;
        cfg_enable = 1'b0;
        cfg_period = '0;
        repeat (3) @(negedge ACLK);

        // Reset state
        chk("rst_awvalid", {31'b0, M_AXI_AWVALID}, 0);
        chk("rst_wvalid", {31'b0, M_AXI_WVALID}, 0);
        chk("rst_arvalid", {31'b0, M_AXI_ARVALID}, 0);
        chk("rst_readies", {30'b0, M_AXI_BREADY, M_AXI_RREADY}, 0);
        chk("rst_addr", M_AXI_AWADDR | M_AXI_ARADDR | M_AXI_WDATA, 0);
        chk("rst_prot", {26'b0, M_AXI_AWPROT, M_AXI_ARPROT}, 0);
        chk("rst_result", result_data, 0);
        chk("rst_flags", {28'b0, result_valid, busy, err_resp, err_timeout}, 0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Nominal: done on 2nd poll, COUNT=0x1234
        cfg_period = 24'd10;
        push_scan(2, 1'b1, 32'h1234);
        cfg_enable = 1'b1;
        wait_sb("nominal_drain", 500);
        cfg_enable = 1'b0;
        wait_idle("nominal_idle", 50);
        chk("nominal_data", result_data, 32'h1234);
        chk("nominal_errs", {30'b0, err_resp, err_timeout}, 0);

        // Backpressure: AW late by 3, random AR/R delays
        aw_dly = 3; ar_fix = -1; ar_max = 5; r_max = 5;
        cfg_period = 24'd3;
        push_scan(2, 1'b1, 32'h1234);
        cfg_enable = 1'b1;
        wait_sb("bp_drain", 800);
        cfg_enable = 1'b0;
        wait_idle("bp_idle", 50);
        aw_dly = 0; ar_fix = 0; ar_max = 0; r_max = 0;

        // Timeout: STATUS never done, POLL_MAX=4
        done_on = 0;
        push_scan(4, 1'b0, 32'h0);
        cfg_enable = 1'b1;
        wait_sb("to_drain", 500);
        n = 0;
        while (!err_timeout && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        chk("to_flag", {31'b0, err_timeout}, 1);
        chk("to_resp_clear", {31'b0, err_resp}, 0);
        push_scan(0, 1'b0, 32'h0);
        wait_sb("to_rescan", 100);
        cfg_enable = 1'b0;
        wait_idle("to_idle", 50);
        chk("to_sticky", {31'b0, err_timeout}, 1);

        // Error: SLVERR on B, no reads, enable edge clears flags
        done_on = 2; bresp_cfg = 2'b10; cfg_period = 24'd20;
        push_scan(0, 1'b0, 32'h0);
        cfg_enable = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("err_to_cleared", {31'b0, err_timeout}, 0);
        n = 0;
        while (!err_resp && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("err_resp_set", {31'b0, err_resp}, 1);
        cfg_enable = 1'b0;
        wait_idle("err_idle", 50);
        wait_sb("err_drain", 5);
        bresp_cfg = 2'b00;
        count_val = 32'hCAFE_0042;
        push_scan(2, 1'b1, 32'hCAFE_0042);
        cfg_enable = 1'b1;
        repeat (2) @(negedge ACLK);
        chk("err_resp_cleared", {31'b0, err_resp}, 0);
        wait_sb("err_rescan", 500);
        cfg_enable = 1'b0;
        wait_idle("err_rescan_idle", 50);

        // Abort: drop enable while ARVALID stalls
        ar_fix = 6; cfg_period = 24'd2;
        aw_q.push_back(BASE);
        w_q.push_back(32'h1);
        ar_q.push_back(BASE + 32'h4);
        cfg_enable = 1'b1;
        n = 0;
        while (!M_AXI_ARVALID && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("abort_arvalid", {31'b0, M_AXI_ARVALID}, 1);
        cfg_enable = 1'b0;
        wait_idle("abort_idle", 100);
        wait_sb("abort_drain", 5);
        chk("abort_r_taken", {31'b0, M_AXI_RVALID}, 0);
        ar_fix = 0;

`ifdef BTI_SCAN_TIMESTAMP_EN
        // Timestamp: two consecutive results
        done_on = 1; count_val = 32'h55; cfg_period = 24'd5;
        ts_n = 0;
        push_scan(1, 1'b1, 32'h55);
        push_scan(1, 1'b1, 32'h55);
        cfg_enable = 1'b1;
        wait_sb("ts_drain", 400);
        cfg_enable = 1'b0;
        wait_idle("ts_idle", 50);
        chk("ts_delta", ts_v[1] - ts_v[0], 32'(cyc_v[1] - cyc_v[0]));
        done_on = 2;
`endif

        // Async reset during a stalled write
        aw_dly = 5; w_dly = 5; cfg_period = 24'd2;
        cfg_enable = 1'b1;
        n = 0;
        while (!M_AXI_AWVALID && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("rst_mid_seen", {31'b0, M_AXI_AWVALID}, 1);
        ARESETN = 1'b0;
        #1;
        chk("rst_mid_valids", {29'b0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
        chk("rst_mid_busy", {31'b0, busy}, 0);
        repeat (3) @(negedge ACLK);
        chk("final_queue", pending(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
